// File: rtl/sm83_bus_fabric.sv
// Table-driven CPU memory fabric: decodes accesses into address windows, inserts
// per-window wait states, blocks read-only writes and records access faults.
module sm83_bus_fabric #(
  parameter int                            NUM_REGIONS  = 4,
  parameter int                            ADDR_W       = 16,
  parameter int                            DATA_W       = 8,
  parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_BASE  = {16'hC000, 16'hA000, 16'h8000, 16'h0000},
  parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_LIMIT = {16'hDFFF, 16'hBFFF, 16'h9FFF, 16'h7FFF},
  parameter logic [NUM_REGIONS-1:0]        REGION_RO    = 4'b0001,
  parameter logic [NUM_REGIONS*4-1:0]      REGION_WAIT  = {4'd0, 4'd2, 4'd1, 4'd0},
  parameter logic [DATA_W-1:0]             OPEN_BUS     = 8'hFF
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            cpu_req,
  input  logic                            cpu_we,
  input  logic [ADDR_W-1:0]               cpu_addr,
  input  logic [DATA_W-1:0]               cpu_wdata,
  output logic                            cpu_ready,
  output logic [DATA_W-1:0]               cpu_rdata,
  output logic [NUM_REGIONS-1:0]          mem_sel,
  output logic [ADDR_W-1:0]               mem_addr,
  output logic [DATA_W-1:0]               mem_wdata,
  output logic [NUM_REGIONS-1:0]          mem_wen,
  input  logic [NUM_REGIONS*DATA_W-1:0]   mem_rdata,
  output logic                            fault,
  output logic [ADDR_W-1:0]               fault_addr,
  input  logic                            fault_clr,
  output logic [7:0]                      ro_wr_count
);

  localparam int IDX_W = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  function automatic logic [ADDR_W-1:0] f_base(input logic [IDX_W-1:0] idx);
    return REGION_BASE[idx*ADDR_W +: ADDR_W];
  endfunction

  function automatic logic [ADDR_W-1:0] f_limit(input logic [IDX_W-1:0] idx);
    return REGION_LIMIT[idx*ADDR_W +: ADDR_W];
  endfunction

  function automatic logic [3:0] f_wait(input logic [IDX_W-1:0] idx);
    return REGION_WAIT[idx*4 +: 4];
  endfunction

  function automatic logic [NUM_REGIONS-1:0] f_onehot(input logic [IDX_W-1:0] idx);
    logic [NUM_REGIONS-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // Returns {hit, index}; scanning from the top down lets the lowest index win on overlap.
  function automatic logic [IDX_W:0] f_decode(input logic [ADDR_W-1:0] a);
    logic             hit;
    logic [IDX_W-1:0] idx;
    hit = 1'b0;
    idx = '0;
    for (int r = NUM_REGIONS - 1; r >= 0; r--) begin
      if ((a >= f_base(IDX_W'(r))) && (a <= f_limit(IDX_W'(r)))) begin
        hit = 1'b1;
        idx = IDX_W'(r);
      end
    end
    return {hit, idx};
  endfunction

  logic [IDX_W:0]         w_dec;
  logic                   w_hit;
  logic [IDX_W-1:0]       w_idx;
  logic                   w_ro;
  logic [3:0]             w_wait;
  logic [ADDR_W-1:0]      w_off;
  logic [DATA_W-1:0]      w_rdata;

  assign w_dec  = f_decode(cpu_addr);
  assign w_hit  = w_dec[IDX_W];
  assign w_idx  = w_dec[IDX_W-1:0];
  assign w_ro   = REGION_RO[w_idx];
  assign w_wait = w_hit ? f_wait(w_idx) : 4'd0;
  assign w_off  = w_hit ? (cpu_addr - f_base(w_idx)) : {ADDR_W{1'b0}};

  state_t                 r_state;
  logic [3:0]             r_cnt;
  logic                   r_we;
  logic                   r_hit;
  logic [IDX_W-1:0]       r_idx;
  logic [ADDR_W-1:0]      r_addr;
  logic                   r_wr_ok;
  logic                   r_fault_ev;
  logic                   r_ro_ev;
  logic                   r_ready;
  logic [NUM_REGIONS-1:0] r_mem_sel;
  logic [ADDR_W-1:0]      r_mem_addr;
  logic [DATA_W-1:0]      r_mem_wdata;
  logic [NUM_REGIONS-1:0] r_mem_wen;
  logic                   r_fault;
  logic [ADDR_W-1:0]      r_fault_addr;
  logic [7:0]             r_ro_cnt;

  // Access sequencer plus fault and read-only-write bookkeeping.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_cnt        <= 4'd0;
      r_we         <= 1'b0;
      r_hit        <= 1'b0;
      r_idx        <= '0;
      r_addr       <= '0;
      r_wr_ok      <= 1'b0;
      r_fault_ev   <= 1'b0;
      r_ro_ev      <= 1'b0;
      r_ready      <= 1'b0;
      r_mem_sel    <= '0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_mem_wen    <= '0;
      r_fault      <= 1'b0;
      r_fault_addr <= '0;
      r_ro_cnt     <= 8'd0;
    end else begin
      r_ready   <= 1'b0;
      r_mem_wen <= '0;
      case (r_state)
        ST_IDLE: begin
          if (cpu_req) begin
            r_we        <= cpu_we;
            r_hit       <= w_hit;
            r_idx       <= w_idx;
            r_addr      <= cpu_addr;
            r_cnt       <= w_wait;
            r_wr_ok     <= cpu_we & w_hit & ~w_ro;
            r_fault_ev  <= ~w_hit | (cpu_we & w_ro);
            r_ro_ev     <= cpu_we & w_hit & w_ro;
            r_mem_sel   <= w_hit ? f_onehot(w_idx) : {NUM_REGIONS{1'b0}};
            r_mem_addr  <= w_off;
            r_mem_wdata <= cpu_wdata;
            // With no wait states the only WAIT cycle is the strobe cycle.
            if ((w_wait == 4'd0) && cpu_we && w_hit && !w_ro) begin
              r_mem_wen <= f_onehot(w_idx);
            end
            r_state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
            // Write strobe lands in the last WAIT cycle, once wait states have elapsed.
            if ((r_cnt == 4'd1) && r_wr_ok) begin
              r_mem_wen <= r_mem_sel;
            end
          end else begin
            r_ready <= 1'b1;
            r_state <= ST_RESP;
          end
        end
        ST_RESP: begin
          r_mem_sel   <= '0;
          r_mem_addr  <= '0;
          r_mem_wdata <= '0;
          if (r_ro_ev && (r_ro_cnt != 8'hFF)) begin
            r_ro_cnt <= r_ro_cnt + 8'd1;
          end
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase

      // A clear in the same cycle as a new fault wins and the new event is dropped.
      if (fault_clr) begin
        r_fault      <= 1'b0;
        r_fault_addr <= '0;
      end else if ((r_state == ST_RESP) && r_fault_ev && !r_fault) begin
        r_fault      <= 1'b1;
        r_fault_addr <= r_addr;
      end
    end
  end

  // Read data follows the 1-cycle synchronous memory, so it is steered during the response cycle.
  always_comb begin
    w_rdata = '0;
    if (r_ready) begin
      if (r_we) begin
        w_rdata = '0;
      end else if (r_hit) begin
        w_rdata = mem_rdata[r_idx*DATA_W +: DATA_W];
      end else begin
        w_rdata = OPEN_BUS;
      end
    end else begin
      w_rdata = '0;
    end
  end

  assign cpu_ready   = r_ready;
  assign cpu_rdata   = w_rdata;
  assign mem_sel     = r_mem_sel;
  assign mem_addr    = r_mem_addr;
  assign mem_wdata   = r_mem_wdata;
  assign mem_wen     = r_mem_wen;
  assign fault       = r_fault;
  assign fault_addr  = r_fault_addr;
  assign ro_wr_count = r_ro_cnt;

endmodule

// File: tb/tb_sm83_bus_fabric.sv
// Directed and randomized checks of sm83_bus_fabric against a region-table
// reference model and a synchronous-read memory stub.
module tb_sm83_bus_fabric;
  localparam int NR = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_req;
  logic        cpu_we;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_ready;
  logic [7:0]  cpu_rdata;
  logic [3:0]  mem_sel;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [3:0]  mem_wen;
  logic [31:0] mem_rdata;
  logic        fault;
  logic [15:0] fault_addr;
  logic        fault_clr;
  logic [7:0]  ro_wr_count;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0]  stub [int];
  logic [7:0]  rd [NR];
  logic [7:0]  exp_mem [int];
  logic        exp_fault;
  logic [15:0] exp_faddr;
  int          exp_ro;

  always #5 clk = ~clk;

  sm83_bus_fabric dut (
    .clk(clk), .rst_n(rst_n), .cpu_req(cpu_req), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_ready(cpu_ready),
    .cpu_rdata(cpu_rdata), .mem_sel(mem_sel), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wen(mem_wen), .mem_rdata(mem_rdata),
    .fault(fault), .fault_addr(fault_addr), .fault_clr(fault_clr),
    .ro_wr_count(ro_wr_count)
  );

  function automatic int base_of(input int r);
    case (r)
      0: return 32'h0000;
      1: return 32'h8000;
      2: return 32'hA000;
      default: return 32'hC000;
    endcase
  endfunction

  function automatic int limit_of(input int r);
    case (r)
      0: return 32'h7FFF;
      1: return 32'h9FFF;
      2: return 32'hBFFF;
      default: return 32'hDFFF;
    endcase
  endfunction

  function automatic int wait_of(input int r);
    case (r)
      1: return 1;
      2: return 2;
      default: return 0;
    endcase
  endfunction

  function automatic bit ro_of(input int r);
    return (r == 0);
  endfunction

  function automatic int region_of(input logic [15:0] a);
    int r;
    r = -1;
    for (int i = 0; i < NR; i++) begin
      if (r < 0 && int'(a) >= base_of(i) && int'(a) <= limit_of(i)) r = i;
    end
    return r;
  endfunction

  function automatic logic [7:0] init_val(input int r, input logic [15:0] off);
    logic [2:0] rr;
    rr = 3'(r);
    return off[7:0] ^ off[15:8] ^ {rr, 5'b0} ^ 8'h6D;
  endfunction

  // Memory stub: 1-cycle synchronous read per region; writes are applied by the access task.
  always @(posedge clk) begin
    for (int r = 0; r < NR; r++) begin
      rd[r] <= stub.exists(r * 65536 + int'(mem_addr)) ? stub[r * 65536 + int'(mem_addr)]
                                                       : init_val(r, mem_addr);
    end
  end
  assign mem_rdata = {rd[3], rd[2], rd[1], rd[0]};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_status(input string tag);
    chk({tag, "_fault"}, {31'd0, fault}, {31'd0, exp_fault});
    chk({tag, "_faddr"}, {16'd0, fault_addr}, {16'd0, exp_faddr});
    chk({tag, "_rocnt"}, {24'd0, ro_wr_count}, exp_ro);
  endtask

  // Caller is at a negedge with the fabric idle; returns at the negedge after cpu_ready.
  task automatic do_access(input logic we, input logic [15:0] addr, input logic [7:0] wd,
                           input bit clr_resp, output logic [7:0] got_rd, output int ready_k);
    int          r, lat, wen_n, wen_k;
    logic [3:0]  wen_v, exp_sel;
    logic [7:0]  wen_d, exp_rd;
    logic [15:0] exp_off;
    bit          sel_ok, addr_ok, fev;
    r       = region_of(addr);
    lat     = 2 + ((r >= 0) ? wait_of(r) : 0);
    exp_sel = (r >= 0) ? 4'(1 << r) : 4'b0;
    exp_off = (r >= 0) ? 16'(int'(addr) - base_of(r)) : 16'h0;
    if (we) exp_rd = 8'h00;
    else if (r < 0) exp_rd = 8'hFF;
    else exp_rd = exp_mem.exists(int'(addr)) ? exp_mem[int'(addr)] : init_val(r, exp_off);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
    @(posedge clk);
    ready_k = 0; wen_n = 0; wen_k = 0; wen_v = 4'b0; wen_d = 8'h00; got_rd = 8'h00;
    sel_ok = 1'b1; addr_ok = 1'b1;
    for (int k = 1; k <= 20 && ready_k == 0; k++) begin
      @(negedge clk);
      if (k == 1) begin
        cpu_req = 1'b0; cpu_we = 1'($urandom); cpu_addr = 16'($urandom); cpu_wdata = 8'($urandom);
      end
      if (mem_sel !== exp_sel) sel_ok = 1'b0;
      if (r >= 0 && mem_addr !== exp_off) addr_ok = 1'b0;
      if (mem_wen !== 4'b0) begin
        wen_n++; wen_k = k; wen_v = mem_wen; wen_d = mem_wdata;
        for (int i = 0; i < NR; i++) if (mem_wen[i]) stub[i * 65536 + int'(mem_addr)] = mem_wdata;
      end
      if (cpu_ready === 1'b1) begin
        ready_k = k; got_rd = cpu_rdata;
        if (clr_resp) fault_clr = 1'b1;
      end
    end
    chk("latency", ready_k, lat);
    chk("rdata", {24'd0, got_rd}, {24'd0, exp_rd});
    chk("sel_stable", {31'd0, sel_ok}, 32'd1);
    chk("addr_stable", {31'd0, addr_ok}, 32'd1);
    if (we && r >= 0 && !ro_of(r)) begin
      chk("wen_count", wen_n, 1);
      chk("wen_cycle", wen_k, lat - 1);
      chk("wen_onehot", {28'd0, wen_v}, {28'd0, exp_sel});
      chk("wen_data", {24'd0, wen_d}, {24'd0, wd});
      exp_mem[int'(addr)] = wd;
    end else begin
      chk("wen_none", wen_n, 0);
    end
    @(negedge clk);
    fault_clr = 1'b0;
    chk("ready_pulse", {31'd0, cpu_ready}, 32'd0);
    chk("sel_idle", {28'd0, mem_sel}, 32'd0);
    fev = (r < 0) || (we && ro_of(r));
    if (clr_resp) begin
      exp_fault = 1'b0; exp_faddr = 16'h0;
    end else if (fev && !exp_fault) begin
      exp_fault = 1'b1; exp_faddr = addr;
    end
    if (r >= 0 && we && ro_of(r) && exp_ro < 255) exp_ro++;
    chk_status("post");
  endtask

  task automatic pulse_clr();
    fault_clr = 1'b1;
    @(negedge clk);
    fault_clr = 1'b0;
    exp_fault = 1'b0; exp_faddr = 16'h0;
    @(negedge clk);
    chk_status("clr");
  endtask

  initial begin
    logic [7:0]  rdv;
    logic [15:0] a;
    int          lat, bad, pick, rg;
    logic [15:0] bnd [6];
    bnd = '{16'h7FFF, 16'h8000, 16'h9FFF, 16'hA000, 16'hDFFF, 16'hE000};
    rst_n = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 16'h0; cpu_wdata = 8'h0; fault_clr = 1'b0;
    exp_fault = 1'b0; exp_faddr = 16'h0; exp_ro = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", {31'd0, cpu_ready}, 32'd0);
    chk("rst_rdata", {24'd0, cpu_rdata}, 32'd0);
    chk("rst_sel_wen", {24'd0, mem_sel, mem_wen}, 32'd0);
    chk("rst_addr_wdata", {8'd0, mem_addr, mem_wdata}, 32'd0);
    chk_status("rst");
    rst_n = 1'b1;

    do_access(1'b0, 16'h0150, 8'h00, 1'b0, rdv, lat);
    chk("t1_rdata", {24'd0, rdv}, 32'h3C);
    do_access(1'b1, 16'h0100, 8'h55, 1'b0, rdv, lat);
    chk("t2_status", {15'd0, fault, fault_addr}, 32'h1_0100);
    chk("t2_rocnt", {24'd0, ro_wr_count}, 32'd1);
    pulse_clr();
    do_access(1'b0, 16'hA123, 8'h00, 1'b0, rdv, lat);
    chk("t3_latency", lat, 4);
    do_access(1'b1, 16'hC010, 8'hAA, 1'b0, rdv, lat);
    do_access(1'b0, 16'hC010, 8'h00, 1'b0, rdv, lat);
    chk("t3_readback", {24'd0, rdv}, 32'hAA);
    do_access(1'b0, 16'hFF80, 8'h00, 1'b0, rdv, lat);
    chk("t4_open_bus", {24'd0, rdv}, 32'hFF);
    do_access(1'b0, 16'hE000, 8'h00, 1'b0, rdv, lat);
    chk("t4_first_addr", {16'd0, fault_addr}, 32'hFF80);
    pulse_clr();
    for (int i = 0; i < 6; i++) do_access(1'b0, bnd[i], 8'h00, 1'b0, rdv, lat);
    pulse_clr();
    do_access(1'b0, 16'hE123, 8'h00, 1'b1, rdv, lat);
    chk("clr_wins", {31'd0, fault}, 32'd0);

    do_access(1'b0, 16'hF000, 8'h00, 1'b0, rdv, lat);
    for (int v = 0; v < 2; v++) begin
      cpu_req = 1'b1; cpu_we = 1'(v); cpu_addr = (v == 0) ? 16'h8000 : 16'hA000; cpu_wdata = 8'h99;
      @(posedge clk);
      @(negedge clk);
      cpu_req = 1'b0; rst_n = 1'b0;
      bad = 0;
      repeat (4) begin
        @(negedge clk);
        if (cpu_ready !== 1'b0 || mem_wen !== 4'b0) bad++;
      end
      rst_n = 1'b1;
      exp_fault = 1'b0; exp_faddr = 16'h0; exp_ro = 0;
      chk("t5_abort", bad, 0);
      chk_status("t5_rst");
    end
    do_access(1'b0, 16'h8000, 8'h00, 1'b0, rdv, lat);
    chk("t5_fresh_latency", lat, 3);

    for (int i = 0; i < 300; i++) do_access(1'b1, 16'h0000, 8'(i), 1'b0, rdv, lat);
    chk("t6_saturated", {24'd0, ro_wr_count}, 32'd255);

    for (int i = 0; i < 150; i++) begin
      pick = $urandom_range(0, 9);
      if (pick < 8) begin
        rg = pick % 4;
        a = 16'(base_of(rg) + $urandom_range(0, 31));
      end else if (pick == 8) begin
        a = 16'($urandom);
      end else begin
        a = 16'(32'hE000 + $urandom_range(0, 32'h1FFF));
      end
      if ($urandom_range(0, 15) == 0) pulse_clr();
      do_access(1'($urandom), a, 8'($urandom), ($urandom_range(0, 15) == 0), rdv, lat);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
